clock_scaler_mc: RTL and testbench

CLOCK_SCALER_MC -- requirements
Module: clock_scaler_mc

---
 rtl/clock_scaler_mc.sv | 116 +++++++++++
 tb/tb_clock_scaler_mc.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/clock_scaler_mc.sv
// Multi-channel clock divider: one master counter, per-channel phase offsets and a shared duty.
// New settings take effect only at a period boundary, or immediately while the scaler is stopped.
module clock_scaler_mc #(
  parameter int CNT_W       = 16,
  parameter int NUM_CH      = 4,
  parameter int DEFAULT_DIV = 6250
) (
  input  logic                    clk_in,
  input  logic                    rst,
  input  logic                    en,
  input  logic                    load,
  input  logic [CNT_W-1:0]        div_in,
  input  logic [CNT_W-1:0]        duty_in,
  input  logic [NUM_CH*CNT_W-1:0] phase_in,
  output logic [NUM_CH-1:0]       clk_scaled_out,
  output logic                    tick_out,
  output logic                    cfg_pending_out,
  output logic                    cfg_ack_out,
  output logic                    cfg_err_out
);

  logic [CNT_W-1:0]        r_cnt;
  logic [CNT_W-1:0]        r_div_act;
  logic [CNT_W-1:0]        r_duty_act;
  logic [NUM_CH*CNT_W-1:0] r_phase_act;
  logic                    r_pend;
  logic [CNT_W-1:0]        r_div_pend;
  logic [CNT_W-1:0]        r_duty_pend;
  logic [NUM_CH*CNT_W-1:0] r_phase_pend;
  logic [NUM_CH-1:0]       r_clk;
  logic                    r_tick;
  logic                    r_ack;
  logic                    r_err;

  logic [NUM_CH-1:0] w_ph_ok;
  logic [NUM_CH-1:0] w_hi;
  logic [CNT_W:0]    w_ch [NUM_CH];
  logic              w_load_ok;
  logic              w_wrap;

  generate
    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
      logic [CNT_W-1:0] w_ph;
      assign w_ph        = r_phase_act[gi*CNT_W +: CNT_W];
      assign w_ph_ok[gi] = phase_in[gi*CNT_W +: CNT_W] < div_in;
      // One extra bit keeps cnt+div-phase from overflowing for large divisors.
      assign w_ch[gi] = (r_cnt >= w_ph) ? ({1'b0, r_cnt} - {1'b0, w_ph})
                                        : ({1'b0, r_cnt} + {1'b0, r_div_act} - {1'b0, w_ph});
      assign w_hi[gi] = w_ch[gi] < {1'b0, r_duty_act};
    end
  endgenerate

  assign w_load_ok = load && (div_in >= CNT_W'(2)) && (&w_ph_ok);
  assign w_wrap    = en && (r_cnt >= r_div_act - CNT_W'(1));

  always_ff @(posedge clk_in) begin
    if (rst) begin
      r_cnt        <= '0;
      r_div_act    <= CNT_W'(DEFAULT_DIV);
      r_duty_act   <= CNT_W'(DEFAULT_DIV / 2);
      r_phase_act  <= '0;
      r_pend       <= 1'b0;
      r_div_pend   <= '0;
      r_duty_pend  <= '0;
      r_phase_pend <= '0;
      r_clk        <= '0;
      r_tick       <= 1'b0;
      r_ack        <= 1'b0;
      r_err        <= 1'b0;
    end else begin
      r_ack  <= 1'b0;
      r_err  <= load && !w_load_ok;
      r_tick <= w_wrap;
      r_clk  <= en ? w_hi : '0;
      if (en) begin
        r_cnt <= w_wrap ? '0 : r_cnt + CNT_W'(1);
        if (w_wrap && r_pend) begin
          r_div_act   <= r_div_pend;
          r_duty_act  <= r_duty_pend;
          r_phase_act <= r_phase_pend;
          r_ack       <= 1'b1;
          r_pend      <= 1'b0;
        end
        // A load in the wrap cycle overrides the pend clear above: it waits for the next wrap.
        if (w_load_ok) begin
          r_div_pend   <= div_in;
          r_duty_pend  <= duty_in;
          r_phase_pend <= phase_in;
          r_pend       <= 1'b1;
        end
      end else begin
        r_cnt <= '0;
        if (w_load_ok) begin
          r_div_act   <= div_in;
          r_duty_act  <= duty_in;
          r_phase_act <= phase_in;
          r_ack       <= 1'b1;
          r_pend      <= 1'b0;
        end else if (r_pend) begin
          r_div_act   <= r_div_pend;
          r_duty_act  <= r_duty_pend;
          r_phase_act <= r_phase_pend;
          r_ack       <= 1'b1;
          r_pend      <= 1'b0;
        end
      end
    end
  end

  assign clk_scaled_out  = r_clk;
  assign tick_out        = r_tick;
  assign cfg_pending_out = r_pend;
  assign cfg_ack_out     = r_ack;
  assign cfg_err_out     = r_err;

endmodule

// File: tb/tb_clock_scaler_mc.sv
// Cycle-level bench for clock_scaler_mc: a behavioural model pushes expected outputs per cycle,
// the monitor pops and compares them; directed counters confirm the headline behaviours.
module tb_clock_scaler_mc;
  localparam int CNT_W = 16;
  localparam int NUM_CH = 4;

  logic                    clk_in = 1'b0;
  logic                    rst = 1'b1;
  logic                    en = 1'b0;
  logic                    load = 1'b0;
  logic [CNT_W-1:0]        div_in = '0;
  logic [CNT_W-1:0]        duty_in = '0;
  logic [NUM_CH*CNT_W-1:0] phase_in = '0;
  logic [NUM_CH-1:0]       clk_scaled_out;
  logic                    tick_out, cfg_pending_out, cfg_ack_out, cfg_err_out;

  clock_scaler_mc #(.CNT_W(CNT_W), .NUM_CH(NUM_CH), .DEFAULT_DIV(10)) dut (
    .clk_in(clk_in), .rst(rst), .en(en), .load(load),
    .div_in(div_in), .duty_in(duty_in), .phase_in(phase_in),
    .clk_scaled_out(clk_scaled_out), .tick_out(tick_out),
    .cfg_pending_out(cfg_pending_out), .cfg_ack_out(cfg_ack_out), .cfg_err_out(cfg_err_out)
  );

  always #5 clk_in = ~clk_in;

  typedef struct packed {
    logic [NUM_CH-1:0] clk;
    logic tick, pend, ack, err;
  } exp_t;
  exp_t sb_q[$];

  int n_checks = 0;
  int n_fail = 0;

  // Reference model state
  int m_cnt, m_div, m_duty, m_pv, m_pdiv, m_pduty;
  int m_ph[NUM_CH];
  int m_pph[NUM_CH];

  // Directed accumulators
  int hi_acc[NUM_CH];
  int tick_acc, ack_acc, err_acc;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_checks++;
    if (obs !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  task automatic clear_acc();
    for (int i = 0; i < NUM_CH; i++) hi_acc[i] = 0;
    tick_acc = 0; ack_acc = 0; err_acc = 0;
  endtask

  task automatic step(input logic a_rst, input logic a_en, input logic a_load,
                      input logic [CNT_W-1:0] a_div, input logic [CNT_W-1:0] a_duty,
                      input logic [NUM_CH*CNT_W-1:0] a_ph);
    exp_t e;
    exp_t got;
    bit ok, wrap;
    int ch;
    logic [NUM_CH*CNT_W-1:0] ph_v;
    ph_v = a_ph;
    e = '0;
    if (a_rst) begin
      m_cnt = 0; m_div = 10; m_duty = 5; m_pv = 0; m_pdiv = 0; m_pduty = 0;
      for (int i = 0; i < NUM_CH; i++) begin m_ph[i] = 0; m_pph[i] = 0; end
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        ch = (m_cnt - m_ph[i] + m_div) % m_div;
        e.clk[i] = a_en && (ch < m_duty);
      end
      wrap = a_en && (m_cnt == m_div - 1);
      e.tick = wrap;
      ok = a_load && (int'(a_div) >= 2);
      for (int i = 0; i < NUM_CH; i++)
        if (int'(ph_v[i*CNT_W +: CNT_W]) >= int'(a_div)) ok = 0;
      e.err = a_load && !ok;
      if (a_en) begin
        m_cnt = wrap ? 0 : m_cnt + 1;
        if (wrap && m_pv != 0) begin
          m_div = m_pdiv; m_duty = m_pduty;
          for (int i = 0; i < NUM_CH; i++) m_ph[i] = m_pph[i];
          e.ack = 1'b1; m_pv = 0;
        end
        if (ok) begin
          m_pdiv = int'(a_div); m_pduty = int'(a_duty);
          for (int i = 0; i < NUM_CH; i++) m_pph[i] = int'(ph_v[i*CNT_W +: CNT_W]);
          m_pv = 1;
        end
      end else begin
        m_cnt = 0;
        if (ok) begin
          m_div = int'(a_div); m_duty = int'(a_duty);
          for (int i = 0; i < NUM_CH; i++) m_ph[i] = int'(ph_v[i*CNT_W +: CNT_W]);
          e.ack = 1'b1; m_pv = 0;
        end else if (m_pv != 0) begin
          m_div = m_pdiv; m_duty = m_pduty;
          for (int i = 0; i < NUM_CH; i++) m_ph[i] = m_pph[i];
          e.ack = 1'b1; m_pv = 0;
        end
      end
      e.pend = (m_pv != 0);
    end
    sb_q.push_back(e);

    rst = a_rst; en = a_en; load = a_load;
    div_in = a_div; duty_in = a_duty; phase_in = a_ph;
    @(posedge clk_in);
    #1;
    got = sb_q.pop_front();
    check_eq("clk_scaled_out", 32'(clk_scaled_out), 32'(got.clk));
    check_eq("tick_out", 32'(tick_out), 32'(got.tick));
    check_eq("cfg_pending_out", 32'(cfg_pending_out), 32'(got.pend));
    check_eq("cfg_ack_out", 32'(cfg_ack_out), 32'(got.ack));
    check_eq("cfg_err_out", 32'(cfg_err_out), 32'(got.err));
    for (int i = 0; i < NUM_CH; i++) hi_acc[i] += int'(clk_scaled_out[i]);
    tick_acc += int'(tick_out);
    ack_acc += int'(cfg_ack_out);
    err_acc += int'(cfg_err_out);
    load = 1'b0;
  endtask

  task automatic run(input logic a_en, input int n);
    for (int k = 0; k < n; k++) step(1'b0, a_en, 1'b0, '0, '0, '0);
  endtask

  function automatic logic [NUM_CH*CNT_W-1:0] ph4(input int p0, input int p1, input int p2, input int p3);
    return {CNT_W'(p3), CNT_W'(p2), CNT_W'(p1), CNT_W'(p0)};
  endfunction

  initial begin
    int steps;
    logic [NUM_CH*CNT_W-1:0] rph;

    // Reset and default 10-cycle, 50% operation
    step(1'b1, 1'b0, 1'b0, '0, '0, '0);
    step(1'b1, 1'b1, 1'b1, 16'd4, 16'd1, '0);
    check_eq("reset_outputs", {27'd0, clk_scaled_out, tick_out}, 32'd0);
    check_eq("reset_cfg", {29'd0, cfg_pending_out, cfg_ack_out, cfg_err_out}, 32'd0);
    run(1'b1, 20);
    clear_acc();
    for (int k = 0; k < 10; k++) begin
      run(1'b1, 1);
      check_eq("in_phase", 32'((clk_scaled_out == 4'h0) || (clk_scaled_out == 4'hF)), 32'd1);
    end
    for (int i = 0; i < NUM_CH; i++) check_eq("default_high_cycles", 32'(hi_acc[i]), 32'd5);
    check_eq("default_ticks_per_10", 32'(tick_acc), 32'd1);

    // Stopped load: div 8, duty 2, staggered phases
    run(1'b0, 3);
    step(1'b0, 1'b0, 1'b1, 16'd8, 16'd2, ph4(0, 2, 4, 6));
    check_eq("stopped_load_ack", 32'(cfg_ack_out), 32'd1);
    check_eq("stopped_load_no_pend", 32'(cfg_pending_out), 32'd0);
    run(1'b1, 16);
    clear_acc();
    run(1'b1, 8);
    for (int i = 0; i < NUM_CH; i++) check_eq("div8_high_cycles", 32'(hi_acc[i]), 32'd2);
    check_eq("div8_ticks_per_8", 32'(tick_acc), 32'd1);

    // Running reconfiguration mid-period
    run(1'b0, 2);
    step(1'b0, 1'b0, 1'b1, 16'd10, 16'd5, '0);
    steps = 0;
    while (m_cnt != 4 && steps < 20) begin run(1'b1, 1); steps++; end
    step(1'b0, 1'b1, 1'b1, 16'd6, 16'd3, '0);
    check_eq("running_load_pending", 32'(cfg_pending_out), 32'd1);
    steps = 0;
    clear_acc();
    while (ack_acc == 0 && steps < 30) begin run(1'b1, 1); steps++; end
    check_eq("steps_to_ack", 32'(steps), 32'd5);
    check_eq("ack_with_tick", 32'(tick_out), 32'd1);
    steps = 0;
    clear_acc();
    while (tick_acc == 0 && steps < 30) begin run(1'b1, 1); steps++; end
    check_eq("new_period", 32'(steps), 32'd6);

    // Rejected loads
    clear_acc();
    step(1'b0, 1'b1, 1'b1, 16'd1, 16'd0, '0);
    check_eq("err_div1", 32'(cfg_err_out), 32'd1);
    step(1'b0, 1'b1, 1'b1, 16'd8, 16'd2, ph4(8, 0, 0, 0));
    check_eq("err_phase8", 32'(cfg_err_out), 32'd1);
    check_eq("err_no_pend", 32'(cfg_pending_out), 32'd0);
    run(1'b1, 12);
    check_eq("err_count", 32'(err_acc), 32'd2);
    check_eq("err_no_ack", 32'(ack_acc), 32'd0);

    // Duty extremes
    run(1'b0, 2);
    step(1'b0, 1'b0, 1'b1, 16'd10, 16'd0, ph4(0, 3, 5, 9));
    run(1'b1, 2);
    clear_acc();
    run(1'b1, 20);
    for (int i = 0; i < NUM_CH; i++) check_eq("duty0_high", 32'(hi_acc[i]), 32'd0);
    check_eq("duty0_ticks", 32'(tick_acc), 32'd2);
    run(1'b0, 2);
    step(1'b0, 1'b0, 1'b1, 16'd10, 16'd12, ph4(0, 3, 5, 9));
    run(1'b1, 2);
    clear_acc();
    run(1'b1, 20);
    for (int i = 0; i < NUM_CH; i++) check_eq("duty12_high", 32'(hi_acc[i]), 32'd20);
    check_eq("duty12_ticks", 32'(tick_acc), 32'd2);

    // Pending config lost on reset
    step(1'b0, 1'b1, 1'b1, 16'd4, 16'd1, '0);
    run(1'b1, 2);
    step(1'b1, 1'b1, 1'b0, '0, '0, '0);
    check_eq("rst_clears_pend", 32'(cfg_pending_out), 32'd0);
    clear_acc();
    run(1'b1, 20);
    check_eq("rst_no_ack", 32'(ack_acc), 32'd0);
    check_eq("rst_default_ticks", 32'(tick_acc), 32'd2);

    // Pending config applied on en falling
    step(1'b0, 1'b1, 1'b1, 16'd5, 16'd2, ph4(1, 2, 3, 4));
    run(1'b1, 1);
    step(1'b0, 1'b0, 1'b0, '0, '0, '0);
    check_eq("en_fall_ack", 32'(cfg_ack_out), 32'd1);

    // Random traffic against the model
    for (int k = 0; k < 300; k++) begin
      rph = ph4($urandom_range(0, 11), $urandom_range(0, 11), $urandom_range(0, 11), $urandom_range(0, 11));
      step(1'($urandom_range(0, 60) == 0), 1'($urandom_range(0, 9) != 0), 1'($urandom_range(0, 7) == 0),
           CNT_W'($urandom_range(1, 12)), CNT_W'($urandom_range(0, 13)), rph);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
